// File: rtl/obst_pkg.sv
// Shared encodings and defaults for the obstacle mover and its collision helper.
package obst_pkg;

    localparam logic [1:0] MODE_IDLE   = 2'd0;
    localparam logic [1:0] MODE_MANUAL = 2'd1;
    localparam logic [1:0] MODE_PATROL = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MANUAL,
        S_PATROL
    } state_t;

    localparam int BTN_U = 3;
    localparam int BTN_D = 2;
    localparam int BTN_R = 1;
    localparam int BTN_L = 0;

    localparam int DEF_SCR_W     = 640;
    localparam int DEF_SCR_H     = 480;
    localparam int DEF_PLAYER_SZ = 12;

    function automatic logic onehot4(input logic [3:0] b);
        return (b != 4'd0) && ((b & (b - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/obst_collide.sv
// Combinational edge-contact test between the player sprite and one obstacle,
// producing the raw (unregistered) per-direction movement enables.
module obst_collide
    import obst_pkg::*;
#(
    parameter int COORD_W   = 11,
    parameter int PLAYER_SZ = DEF_PLAYER_SZ
) (
    input  logic [COORD_W-1:0] h_pos,
    input  logic [COORD_W-1:0] v_pos,
    input  logic [COORD_W-1:0] obj_width,
    input  logic [COORD_W-1:0] obj_height,
    input  logic [COORD_W-1:0] player_h,
    input  logic [COORD_W-1:0] player_v,
    input  logic [3:0]         player_color,
    input  logic [3:0]         rect_color,
    output logic               up_en,
    output logic               down_en,
    output logic               left_en,
    output logic               right_en
);

    localparam logic [COORD_W:0] PSZ = (COORD_W+1)'(PLAYER_SZ);

    logic [COORD_W:0] obj_right;
    logic [COORD_W:0] obj_bottom;
    logic [COORD_W:0] ply_right;
    logic [COORD_W:0] ply_bottom;
    logic             h_overlap;
    logic             v_overlap;
    logic             active;

    // One extra bit keeps the far edges from wrapping near the top of the coordinate range.
    assign obj_right  = {1'b0, h_pos} + {1'b0, obj_width};
    assign obj_bottom = {1'b0, v_pos} + {1'b0, obj_height};
    assign ply_right  = {1'b0, player_h} + PSZ;
    assign ply_bottom = {1'b0, player_v} + PSZ;

    // A zero-sized obstacle or a colour match never blocks anything.
    assign active = (player_color != rect_color) && (obj_width != '0) && (obj_height != '0);

    assign h_overlap = ({1'b0, player_h} < obj_right) && (ply_right > {1'b0, h_pos});
    assign v_overlap = ({1'b0, player_v} < obj_bottom) && (ply_bottom > {1'b0, v_pos});

    assign down_en  = !(active && h_overlap && (ply_bottom == {1'b0, v_pos}));
    assign up_en    = !(active && h_overlap && ({1'b0, player_v} == obj_bottom));
    assign right_en = !(active && v_overlap && (ply_right == {1'b0, h_pos}));
    assign left_en  = !(active && v_overlap && ({1'b0, player_h} == obj_right));

endmodule

// File: rtl/obstacle_mover.sv
// One movable rectangular obstacle (idle / manual / patrol) with registered player enables.
// Optional hit counter output enabled by defining OBST_HIT_COUNT_EN.
module obstacle_mover
    import obst_pkg::*;
#(
    parameter int COORD_W   = 11,
    parameter int SCR_W     = DEF_SCR_W,
    parameter int SCR_H     = DEF_SCR_H,
    parameter int PLAYER_SZ = DEF_PLAYER_SZ,
    parameter int STEP      = 1,
    parameter int STEP_DIV  = 4,
    parameter int EDGE_WRAP = 0,
    parameter int H_INIT    = 0,
    parameter int V_INIT    = 0
) (
    input  logic               btnClk,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    input  logic               load,
    input  logic [COORD_W-1:0] hStartPos,
    input  logic [COORD_W-1:0] vStartPos,
    input  logic [COORD_W-1:0] objWidth,
    input  logic [COORD_W-1:0] objHeight,
    input  logic [3:0]         btns,
    input  logic [1:0]         patrol_dir,
    input  logic [COORD_W-1:0] player_hPos,
    input  logic [COORD_W-1:0] player_vPos,
    input  logic [3:0]         player_color,
    input  logic [3:0]         rect_color,
    output logic [COORD_W-1:0] hPos_o,
    output logic [COORD_W-1:0] vPos_o,
    output logic               moving,
    output logic               upEnable,
    output logic               downEnable,
    output logic               leftEnable,
    output logic               rightEnable
`ifdef OBST_HIT_COUNT_EN
    ,
    output logic [7:0]         hit_count
`endif
);

    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic [COORD_W:0]   STEP_X   = (COORD_W+1)'(STEP);
    localparam logic [COORD_W:0]   SCR_W_X  = (COORD_W+1)'(SCR_W);
    localparam logic [COORD_W:0]   SCR_H_X  = (COORD_W+1)'(SCR_H);
    localparam logic [COORD_W-1:0] H_INIT_X = COORD_W'(H_INIT);
    localparam logic [COORD_W-1:0] V_INIT_X = COORD_W'(V_INIT);
    localparam logic               WRAP     = (EDGE_WRAP != 0);

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               tick;
    logic [COORD_W-1:0] h_pos, v_pos, h_next, v_next;
    logic               hdir, vdir, hdir_next, vdir_next;
    logic               zero_size;
    logic [COORD_W:0]   h_lim, v_lim;
    logic [COORD_W:0]   h_inc, h_dec, v_inc, v_dec;
    logic               h_over, h_under, v_over, v_under;
    logic [COORD_W-1:0] h_fwd, h_back, v_fwd, v_back;
    logic               up_raw, down_raw, left_raw, right_raw;

    assign hPos_o = h_pos;
    assign vPos_o = v_pos;

    assign zero_size = (objWidth == '0) || (objHeight == '0);
    assign h_lim     = SCR_W_X - {1'b0, objWidth};
    assign v_lim     = SCR_H_X - {1'b0, objHeight};

    // Underflow shows up in the extra sign bit rather than wrapping through the modulus.
    assign h_inc   = {1'b0, h_pos} + STEP_X;
    assign h_dec   = {1'b0, h_pos} - STEP_X;
    assign v_inc   = {1'b0, v_pos} + STEP_X;
    assign v_dec   = {1'b0, v_pos} - STEP_X;
    assign h_over  = h_inc > h_lim;
    assign h_under = h_dec[COORD_W];
    assign v_over  = v_inc > v_lim;
    assign v_under = v_dec[COORD_W];

    assign h_fwd  = h_over  ? (WRAP ? '0 : h_lim[COORD_W-1:0]) : h_inc[COORD_W-1:0];
    assign h_back = h_under ? (WRAP ? h_lim[COORD_W-1:0] : '0) : h_dec[COORD_W-1:0];
    assign v_fwd  = v_over  ? (WRAP ? '0 : v_lim[COORD_W-1:0]) : v_inc[COORD_W-1:0];
    assign v_back = v_under ? (WRAP ? v_lim[COORD_W-1:0] : '0) : v_dec[COORD_W-1:0];

    assign tick = (state != S_IDLE) && (cnt == CNT_LAST);

    always_comb begin
        next_state = S_IDLE;
        case (mode)
            MODE_MANUAL: next_state = S_MANUAL;
            MODE_PATROL: next_state = S_PATROL;
            default:     next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_next = cnt + CNT_W'(1);
        if (load || (next_state != state) || (state == S_IDLE) || tick) begin
            cnt_next = '0;
        end
    end

    // Load wins over motion; a bounce flips direction on the same tick it clamps.
    always_comb begin
        h_next    = h_pos;
        v_next    = v_pos;
        hdir_next = hdir;
        vdir_next = vdir;
        if (load) begin
            h_next    = hStartPos;
            v_next    = vStartPos;
            hdir_next = patrol_dir[0];
            vdir_next = patrol_dir[1];
        end else if (tick && !zero_size) begin
            if ((state == S_MANUAL) && onehot4(btns)) begin
                if (btns[BTN_R]) h_next = h_fwd;
                if (btns[BTN_L]) h_next = h_back;
                if (btns[BTN_D]) v_next = v_fwd;
                if (btns[BTN_U]) v_next = v_back;
            end else if (state == S_PATROL) begin
                h_next = hdir ? h_fwd : h_back;
                v_next = vdir ? v_fwd : v_back;
                if (!WRAP && (hdir ? h_over : h_under)) hdir_next = !hdir;
                if (!WRAP && (vdir ? v_over : v_under)) vdir_next = !vdir;
            end
        end
    end

    obst_collide #(
        .COORD_W   (COORD_W),
        .PLAYER_SZ (PLAYER_SZ)
    ) u_collide (
        .h_pos        (h_pos),
        .v_pos        (v_pos),
        .obj_width    (objWidth),
        .obj_height   (objHeight),
        .player_h     (player_hPos),
        .player_v     (player_vPos),
        .player_color (player_color),
        .rect_color   (rect_color),
        .up_en        (up_raw),
        .down_en      (down_raw),
        .left_en      (left_raw),
        .right_en     (right_raw)
    );

    always_ff @(posedge btnClk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            h_pos       <= H_INIT_X;
            v_pos       <= V_INIT_X;
            hdir        <= 1'b1;
            vdir        <= 1'b1;
            moving      <= 1'b0;
            upEnable    <= 1'b1;
            downEnable  <= 1'b1;
            leftEnable  <= 1'b1;
            rightEnable <= 1'b1;
        end else begin
            state       <= next_state;
            cnt         <= cnt_next;
            h_pos       <= h_next;
            v_pos       <= v_next;
            hdir        <= hdir_next;
            vdir        <= vdir_next;
            moving      <= load || (h_next != h_pos) || (v_next != v_pos);
            upEnable    <= up_raw;
            downEnable  <= down_raw;
            leftEnable  <= left_raw;
            rightEnable <= right_raw;
        end
    end

`ifdef OBST_HIT_COUNT_EN
    logic any_fall;

    assign any_fall = (upEnable && !up_raw) || (downEnable && !down_raw) ||
                      (leftEnable && !left_raw) || (rightEnable && !right_raw);

    always_ff @(posedge btnClk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count <= 8'd0;
        end else if (load) begin
            hit_count <= 8'd0;
        end else if (any_fall && (hit_count != 8'hFF)) begin
            hit_count <= hit_count + 8'd1;
        end
    end
`endif

endmodule

// File: doc/obstacle_mover.md
Name: obstacle_mover

Overview:
- Parametrised successor to the single-rectangle obstacle.
- Holds one rectangular obstacle's absolute position with three motion modes: idle, button-driven manual, and autonomous patrol (bounce or wrap).
- Produces registered per-direction movement enables that stop a player's sprite from entering the obstacle unless their colours match.
- Instantiated once per obstacle between the button debouncer and the VGA object renderer; the enables are AND-reduced across instances upstream.

Parameters:
- COORD_W, 11, width of every coordinate/size port and register.
- SCR_W, 640, visible screen width in pixels.
- SCR_H, 480, visible screen height in pixels.
- PLAYER_SZ, 12, player sprite edge length (square).
- STEP, 1, pixels moved per motion tick.
- STEP_DIV, 4, btnClk cycles per motion tick (≥1).
- EDGE_WRAP, 0, 1 = wrap to opposite screen edge; 0 = clamp (manual) or bounce (patrol).
- H_INIT, 0, horizontal position after reset.
- V_INIT, 0, vertical position after reset.

Ports:
- btnClk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  0 idle, 1 manual, 2 patrol, 3 treated as idle.
- load  in  1  synchronous load of start position.
- hStartPos  in  COORD_W  start x, used on load.
- vStartPos  in  COORD_W  start y, used on load.
- objWidth  in  COORD_W  obstacle width, px.
- objHeight  in  COORD_W  obstacle height, px.
- btns  in  4  {U,D,R,L} = bits 3..0, one-hot.
- patrol_dir  in  2  initial patrol direction {vdir,hdir}, captured on load; 1 = +.
- player_hPos  in  COORD_W  player left edge.
- player_vPos  in  COORD_W  player top edge.
- player_color  in  4  player colour.
- rect_color  in  4  obstacle colour.
- hPos_o  out  COORD_W  current obstacle x.
- vPos_o  out  COORD_W  current obstacle y.
- moving  out  1  high for one cycle when the position changed.
- upEnable, downEnable, leftEnable, rightEnable  out  1 each  player may move in that direction.

Behaviour:
- Reset (rst_n low, async): hPos=H_INIT, vPos=V_INIT, hdir=vdir=1, prescaler=0, state=S_IDLE, moving=0, all four enables=1.
- Prescaler: counts 0..STEP_DIV-1 in S_MANUAL/S_PATROL; tick = count==STEP_DIV-1. Cleared on any state change and on load; held at 0 in S_IDLE.
- FSM states are S_IDLE, S_MANUAL and S_PATROL. The next state is decoded from mode every cycle and takes effect the next cycle. The position is not altered by a mode change.
- load has priority over motion: hPos/vPos ← start inputs, {vdir,hdir} ← patrol_dir, moving=1 that cycle.
- Manual move: happens on tick with btns one-hot. Zero or multi-hot btns gives no move.
  - U decrements vPos by STEP; D increments vPos; L decrements hPos; R increments hPos.
  - Limits: x∈[0, SCR_W-objWidth], y∈[0, SCR_H-objHeight].
  - EDGE_WRAP=0: clamp at the limit.
  - EDGE_WRAP=1: a step past a limit lands on the opposite limit.
- Patrol move: on tick, both axes move by STEP in hdir/vdir.
  - EDGE_WRAP=0: if the step would cross a limit, the position is set to the limit and the direction bit flips in the same cycle.
  - EDGE_WRAP=1: wrap as in manual; the direction is unchanged.
- Arithmetic: compute in COORD_W+1 bits so underflow is detected via the sign bit. Never wrap through the modulus.
- moving = 1 exactly when hPos or vPos changed that cycle.
- Collision: uses the registered position (pre-update) and is registered, so 1-cycle latency. Player box = [ph, ph+PLAYER_SZ) × [pv, pv+PLAYER_SZ). Horizontal overlap: ph < hPos+objWidth && ph+PLAYER_SZ > hPos. Vertical overlap is analogous. Let mismatch = player_color != rect_color.
  - downEnable=0 iff hOverlap && pv+PLAYER_SZ==vPos && mismatch.
  - upEnable=0 iff hOverlap && pv==vPos+objHeight && mismatch.
  - rightEnable=0 iff vOverlap && ph+PLAYER_SZ==hPos && mismatch.
  - leftEnable=0 iff vOverlap && ph==hPos+objWidth && mismatch.
- objWidth or objHeight of 0: the obstacle never moves and all enables are 1.

Optional Feature:
- Macro OBST_HIT_COUNT_EN.
- Defined: adds output hit_count[7:0].
  - Increments, saturating at 255, on each cycle in which any enable transitions 1→0.
  - Cleared by reset and by load.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package obst_pkg holds:
  - the mode encodings MODE_IDLE/MANUAL/PATROL;
  - the state enum;
  - the button bit indices BTN_U/D/R/L;
  - default SCR_W/SCR_H/PLAYER_SZ constants.
- One sub-module, obst_collide: purely combinational edge-contact logic producing the four raw enables.
- obstacle_mover registers the obst_collide outputs.

Test Plan:
- Reset with H_INIT=100, V_INIT=50 → hPos_o=100, vPos_o=50, all enables 1, moving 0.
- mode=1, btns=4'b0010, STEP_DIV=4, STEP=1 → hPos_o +1 every 4th cycle. At hPos=640-objWidth it stays clamped (EDGE_WRAP=0) or becomes 0 (EDGE_WRAP=1).
- mode=2, load with hStart=600, objWidth=40, patrol_dir=2'b01, EDGE_WRAP=0 → first tick keeps hPos at 600 and hdir flips; next tick hPos=599.
- Player at (110,38), obstacle at (100,50), size 40×20, colours 3 vs 5 → downEnable=0 one cycle later. With equal colours → downEnable=1.
- btns=4'b1010 (multi-hot) in manual → no motion, moving stays 0. Assert rst_n mid-patrol → outputs return to reset values asynchronously.
- OBST_HIT_COUNT_EN: three separate contact events → hit_count=3; load → 0.
